// File: rtl/lfsr_checker.sv
// Receive-side checker for the 8-bit Fibonacci LFSR generator: self-synchronises, tracks lock, counts errors.
// Optional macro BIT_ERR_COUNT_EN adds a saturating count of flipped bits on LOCKED mismatches.
module lfsr_checker #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] TAPS     = 8'b1011_1000,
    parameter int               LOCK_CNT = 4,
    parameter int               LOSS_CNT = 3,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear_errors,
    output logic             locked,
    output logic             error_pulse,
    output logic [CNT_W-1:0] error_count,
    output logic [WIDTH-1:0] expected
`ifdef BIT_ERR_COUNT_EN
    ,
    output logic [CNT_W-1:0] bit_error_count
`endif
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);
    localparam int PW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t        state;
    logic [MW-1:0] match_cnt;
    logic [LW-1:0] miss_cnt;

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic             hit;
    logic             word_nz;
    logic             err_now;
    logic [MW-1:0]    match_nxt;
    logic [LW-1:0]    miss_nxt;
    logic [CNT_W-1:0] err_base;
    logic [CNT_W-1:0] err_cnt_nxt;

    always_comb begin
        hit         = (in_data == expected);
        word_nz     = |in_data;
        err_now     = in_valid && (state == LOCKED) && !hit;
        match_nxt   = match_cnt + MW'(1);
        miss_nxt    = miss_cnt + LW'(1);
        // A coincident error increments from zero, so the clear never swallows it.
        err_base    = clear_errors ? '0 : error_count;
        err_cnt_nxt = err_now ? sat_inc(err_base) : err_base;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SEARCH;
            expected    <= '0;
            locked      <= 1'b0;
            error_pulse <= 1'b0;
            error_count <= '0;
            match_cnt   <= '0;
            miss_cnt    <= '0;
        end else begin
            error_pulse <= 1'b0;
            error_count <= err_cnt_nxt;
            if (in_valid) begin
                case (state)
                    SEARCH: begin
                        if (word_nz) begin
                            expected  <= lfsr_next(in_data);
                            match_cnt <= '0;
                            state     <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (hit) begin
                            expected  <= lfsr_next(in_data);
                            match_cnt <= match_nxt;
                            if (match_nxt == MW'(LOCK_CNT)) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                miss_cnt <= '0;
                            end
                        end else if (word_nz) begin
                            expected  <= lfsr_next(in_data);
                            match_cnt <= '0;
                        end else begin
                            state <= SEARCH;
                        end
                    end
                    LOCKED: begin
                        // Free-running predictor: a corrupted word never reseeds it.
                        expected <= lfsr_next(expected);
                        if (!hit) begin
                            error_pulse <= 1'b1;
                            miss_cnt    <= miss_nxt;
                            if (miss_nxt == LW'(LOSS_CNT)) begin
                                state    <= SEARCH;
                                locked   <= 1'b0;
                                miss_cnt <= '0;
                            end
                        end else begin
                            miss_cnt <= '0;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

`ifdef BIT_ERR_COUNT_EN
    function automatic logic [PW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PW-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) n = n + PW'(v[i]);
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                 input logic [PW-1:0]    p);
        logic [CNT_W:0] s;
        s = {1'b0, c} + (CNT_W + 1)'(p);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    logic [CNT_W-1:0] bit_base;

    always_comb bit_base = clear_errors ? '0 : bit_error_count;

    always_ff @(posedge clk) begin
        if (reset)
            bit_error_count <= '0;
        else if (err_now)
            bit_error_count <= sat_add(bit_base, popcount(in_data ^ expected));
        else
            bit_error_count <= bit_base;
    end
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: a default instance and a CNT_W=4 instance share one stimulus stream.
module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        clear_errors;

    logic        locked0, error_pulse0, locked1, error_pulse1;
    logic [15:0] error_count0;
    logic [3:0]  error_count1;
    logic [7:0]  expected0, expected1;
`ifdef BIT_ERR_COUNT_EN
    logic [15:0] bit_error_count0;
    logic [3:0]  bit_error_count1;
`endif

    int vecs = 0;
    int miscompares = 0;
    logic [7:0] pred;

    always #5 clk = ~clk;

    lfsr_checker u0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .clear_errors(clear_errors), .locked(locked0), .error_pulse(error_pulse0),
        .error_count(error_count0), .expected(expected0)
`ifdef BIT_ERR_COUNT_EN
        , .bit_error_count(bit_error_count0)
`endif
    );

    lfsr_checker #(.CNT_W(4)) u1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .clear_errors(clear_errors), .locked(locked1), .error_pulse(error_pulse1),
        .error_count(error_count1), .expected(expected1)
`ifdef BIT_ERR_COUNT_EN
        , .bit_error_count(bit_error_count1)
`endif
    );

    function automatic logic [7:0] lnext(input logic [7:0] s);
        return {s[6:0], ^(s & 8'b1011_1000)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: present a word, let the edge take it, sample 1 time unit later.
    task automatic step(input logic v, input logic [7:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        reset        = 1'b0;
        clear_errors = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; clear_errors = 1'b0;
        @(negedge clk);
        step(1'b1, 8'hAA);
        check("rst_locked", 32'(locked0), 32'd0);
        check("rst_count", 32'(error_count0), 32'd0);
        check("rst_expected", 32'(expected0), 32'h00);
        check("rst_pulse", 32'(error_pulse0), 32'd0);

        // Acquire lock back-to-back
        step(1'b1, 8'h01); step(1'b1, 8'h02); step(1'b1, 8'h04); step(1'b1, 8'h08);
        check("lock_early", 32'(locked0), 32'd0);
        step(1'b1, 8'h11);
        check("lock_locked", 32'(locked0), 32'd1);
        check("lock_expected", 32'(expected0), 32'h23);
        check("lock_count", 32'(error_count0), 32'd0);
        check("lock_locked_w4", 32'(locked1), 32'd1);

        // Single corrupted word while locked
        step(1'b1, 8'h23);
        check("t2_expected", 32'(expected0), 32'h47);
        check("t2_nopulse", 32'(error_pulse0), 32'd0);
        step(1'b1, 8'h46);
        check("t2_pulse", 32'(error_pulse0), 32'd1);
        check("t2_count", 32'(error_count0), 32'd1);
        check("t2_locked", 32'(locked0), 32'd1);
        check("t2_freerun", 32'(expected0), 32'h8E);
`ifdef BIT_ERR_COUNT_EN
        check("t2_bitcount", 32'(bit_error_count0), 32'd1);
`endif
        step(1'b1, 8'h8E);
        check("t2_pulse_off", 32'(error_pulse0), 32'd0);
        check("t2_expected2", 32'(expected0), 32'h1C);
        step(1'b0, 8'h00);
        check("idle_pulse", 32'(error_pulse0), 32'd0);
        check("idle_expected", 32'(expected0), 32'h1C);

        // Clear, then three zero words drop lock
        clear_errors = 1'b1;
        step(1'b0, 8'h00);
        check("clr_count", 32'(error_count0), 32'd0);
        check("clr_locked", 32'(locked0), 32'd1);
        step(1'b1, 8'h00);
        check("loss1_count", 32'(error_count0), 32'd1);
        check("loss1_locked", 32'(locked0), 32'd1);
        step(1'b1, 8'h00);
        check("loss2_pulse", 32'(error_pulse0), 32'd1);
        step(1'b1, 8'h00);
        check("loss3_pulse", 32'(error_pulse0), 32'd1);
        check("loss3_count", 32'(error_count0), 32'd3);
        check("loss3_locked", 32'(locked0), 32'd0);
`ifdef BIT_ERR_COUNT_EN
        check("loss3_bitcount", 32'(bit_error_count0), 32'd10);
`endif
        step(1'b1, 8'h01);
        check("reseed_expected", 32'(expected0), 32'h02);
        check("reseed_locked", 32'(locked0), 32'd0);
        check("reseed_count", 32'(error_count0), 32'd3);

        // Zero words from reset never seed
        reset = 1'b1;
        step(1'b0, 8'h00);
        for (int i = 0; i < 20; i++) step(1'b1, 8'h00);
        check("zero_locked", 32'(locked0), 32'd0);
        check("zero_count", 32'(error_count0), 32'd0);
        check("zero_expected", 32'(expected0), 32'h00);

        // Lock with idle gaps
        step(1'b1, 8'h01); repeat (5) step(1'b0, 8'h00);
        step(1'b1, 8'h02); repeat (5) step(1'b0, 8'h00);
        step(1'b1, 8'h04); repeat (5) step(1'b0, 8'h00);
        step(1'b1, 8'h08); repeat (5) step(1'b0, 8'h00);
        check("gap_early", 32'(locked0), 32'd0);
        step(1'b1, 8'h11);
        check("gap_locked", 32'(locked0), 32'd1);
        check("gap_expected", 32'(expected0), 32'h23);
        repeat (5) step(1'b0, 8'h00);

        // Alternate bad/good words: counters saturate, lock holds
        pred = 8'h23;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, pred ^ 8'h01); pred = lnext(pred);
            step(1'b1, pred);         pred = lnext(pred);
        end
        check("sat_count16", 32'(error_count0), 32'd20);
        check("sat_count4", 32'(error_count1), 32'd15);
        check("sat_locked", 32'(locked0), 32'd1);
        check("sat_locked_w4", 32'(locked1), 32'd1);
        check("sat_expected", 32'(expected0), 32'(pred));
`ifdef BIT_ERR_COUNT_EN
        check("sat_bitcount4", 32'(bit_error_count1), 32'd15);
`endif
        clear_errors = 1'b1;
        step(1'b1, pred ^ 8'h03); pred = lnext(pred);
        check("clr_err_count16", 32'(error_count0), 32'd1);
        check("clr_err_count4", 32'(error_count1), 32'd1);
        check("clr_err_pulse", 32'(error_pulse0), 32'd1);
`ifdef BIT_ERR_COUNT_EN
        check("clr_err_bitcount", 32'(bit_error_count0), 32'd2);
`endif
        step(1'b1, pred); pred = lnext(pred);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, pred ^ 8'h80); pred = lnext(pred);
            step(1'b1, pred);         pred = lnext(pred);
        end
        check("five_count", 32'(error_count0), 32'd5);
        check("five_locked", 32'(locked0), 32'd1);

        // Reset while locked with a valid word present
        reset = 1'b1;
        step(1'b1, 8'h55);
        check("rst2_locked", 32'(locked0), 32'd0);
        check("rst2_count", 32'(error_count0), 32'd0);
        check("rst2_expected", 32'(expected0), 32'h00);
        check("rst2_pulse", 32'(error_pulse0), 32'd0);
        step(1'b1, 8'h02);
        check("rst2_seed", 32'(expected0), 32'h04);
        check("rst2_seed_locked", 32'(locked0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
